// File: rtl/irq_ctrl.sv
// Interrupt controller feeding cpu.HWInt[7:2]: per-source sync, level/edge capture,
// pending latch and mask, exposed to software as PENDING/MASK/MODE/ACK bridge registers.
module irq_ctrl #(
  parameter int unsigned          N_SRC     = 3,
  parameter logic [N_SRC-1:0]     SYNC_MASK = 3'b100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:2]       Addr,
  input  logic              WE,
  input  logic [31:0]       Din,
  output logic [31:0]       Dout,
  input  logic [N_SRC-1:0]  src,
  output logic [5:0]        HWInt,
  output logic              irq_any,
  output logic [2:0]        irq_id
);

  localparam int unsigned HW_W   = 6;
  localparam int unsigned ID_W   = 3;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SEL_PENDING = 2'd0;
  localparam logic [1:0] SEL_MASK    = 2'd1;
  localparam logic [1:0] SEL_MODE    = 2'd2;
  localparam logic [1:0] SEL_ACK     = 2'd3;

  logic [N_SRC-1:0] r_sync1;
  logic [N_SRC-1:0] r_sync2;
  logic [N_SRC-1:0] r_prev;
  logic [N_SRC-1:0] r_pending;
  logic [N_SRC-1:0] r_mask;
  logic [N_SRC-1:0] r_mode;
  logic [HW_W-1:0]  r_hwint;
  logic             r_irq_any;
  logic [ID_W-1:0]  r_irq_id;

  logic [1:0]       w_sel;
  logic [N_SRC-1:0] w_s;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_ack;
  logic [N_SRC-1:0] w_mask_next;
  logic [N_SRC-1:0] w_mode_next;
  logic [N_SRC-1:0] w_mode_chg;
  logic [N_SRC-1:0] w_pend_next;
  logic [HW_W-1:0]  w_hwint_next;
  logic [ID_W-1:0]  w_id_next;
  logic             w_unused;

  assign w_sel    = Addr[3:2];
  assign w_unused = ^{Addr[31:4], Din[DATA_W-1:N_SRC]};

  // Next-state for capture, registers and the HWInt vector
  always_comb begin
    w_s          = (SYNC_MASK & r_sync2) | (~SYNC_MASK & src);
    w_rise       = w_s & ~r_prev;
    w_mask_next  = r_mask;
    w_mode_next  = r_mode;
    w_ack        = '0;
    w_id_next    = '0;

    if (WE) begin
      case (w_sel)
        SEL_MASK: w_mask_next = Din[N_SRC-1:0];
        SEL_MODE: w_mode_next = Din[N_SRC-1:0];
        SEL_ACK:  w_ack       = Din[N_SRC-1:0];
        default:  ;
      endcase
    end

    w_mode_chg = w_mode_next ^ r_mode;

    // A freshly re-moded source starts from a clean pending bit; set beats ack
    w_pend_next = ((r_mode & (w_rise | (r_pending & ~w_ack))) | (~r_mode & w_s))
                  & ~w_mode_chg;

    w_hwint_next = HW_W'(r_pending & w_mask_next);

    for (int i = HW_W - 1; i >= 0; i--) begin
      if (w_hwint_next[i]) begin
        w_id_next = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_prev    <= '0;
      r_pending <= '0;
      r_mask    <= '0;
      r_mode    <= '0;
      r_hwint   <= '0;
      r_irq_any <= 1'b0;
      r_irq_id  <= '0;
    end else begin
      r_sync1   <= src;
      r_sync2   <= r_sync1;
      r_prev    <= w_s;
      r_pending <= w_pend_next;
      r_mask    <= w_mask_next;
      r_mode    <= w_mode_next;
      r_hwint   <= w_hwint_next;
      r_irq_any <= |w_hwint_next;
      r_irq_id  <= w_id_next;
    end
  end

  // Read mux shows pre-write register state
  always_comb begin
    Dout = '0;
    case (w_sel)
      SEL_PENDING: Dout = DATA_W'(r_pending);
      SEL_MASK:    Dout = DATA_W'(r_mask);
      SEL_MODE:    Dout = DATA_W'(r_mode);
      SEL_ACK:     Dout = {3'b000, r_irq_any, 25'b0, r_irq_id};
      default:     Dout = '0;
    endcase
  end

  assign HWInt   = r_hwint;
  assign irq_any = r_irq_any;
  assign irq_id  = r_irq_id;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: vector table for level/mask behaviour,
// hand sequences for reset, edge/ACK, synchronised source and mode switch.
module tb_irq_ctrl;

  logic        clk;
  logic        reset;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic [2:0]  src;
  logic [5:0]  HWInt;
  logic        irq_any;
  logic [2:0]  irq_id;

  int n_checks = 0;
  int n_errors = 0;

  irq_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .Addr    (Addr),
    .WE      (WE),
    .Din     (Din),
    .Dout    (Dout),
    .src     (src),
    .HWInt   (HWInt),
    .irq_any (irq_any),
    .irq_id  (irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic        we;
    logic [31:0] din;
    logic [2:0]  src;
    logic        chk_dout;
    logic [31:0] exp_dout;
    logic [5:0]  exp_hw;
    logic [2:0]  exp_id;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [1:0] sel, input logic we, input logic [31:0] din,
                              input logic [2:0] s, input logic cd, input logic [31:0] ed,
                              input logic [5:0] hw, input logic [2:0] id);
    vec_t v;
    v.sel = sel; v.we = we; v.din = din; v.src = s;
    v.chk_dout = cd; v.exp_dout = ed; v.exp_hw = hw; v.exp_id = id;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] sel, input logic we, input logic [31:0] din,
                       input logic [2:0] s);
    Addr = {28'h5A5A5A5, sel};
    WE   = we;
    Din  = din;
    src  = s;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [5:0] hw, input logic [2:0] id);
    chk({name, ".hwint"}, 32'(HWInt), 32'(hw));
    chk({name, ".any"}, 32'(irq_any), 32'(|hw));
    chk({name, ".id"}, 32'(irq_id), 32'(id));
  endtask

  initial begin
    reset = 1'b0;
    drive(2'd0, 1'b0, 32'h0, 3'b111);

    // Reset held with all sources asserted
    for (int c = 0; c < 2; c++) begin
      step();
      chk_out("reset", 6'd0, 3'd0);
      for (int a = 0; a < 4; a++) begin
        drive(2'(a), 1'b0, 32'h0, 3'b111);
        #1;
        chk($sformatf("reset.dout%0d", a), Dout, 32'h0);
      end
    end
    drive(2'd1, 1'b0, 32'h0, 3'b000);
    reset = 1'b1;
    #1;
    chk("release.mask", Dout, 32'h0);
    step();

    // Level src0 then priority/mask on level src1/src2
    vecs.push_back(mk(2'd1, 1'b1, 32'h1, 3'b000, 1'b0, 32'h0, 6'h00, 3'd0));
    vecs.push_back(mk(2'd0, 1'b0, 32'h0, 3'b001, 1'b0, 32'h0, 6'h00, 3'd0));
    vecs.push_back(mk(2'd0, 1'b0, 32'h0, 3'b001, 1'b1, 32'h1, 6'h01, 3'd0));
    vecs.push_back(mk(2'd0, 1'b0, 32'h0, 3'b001, 1'b0, 32'h0, 6'h01, 3'd0));
    vecs.push_back(mk(2'd0, 1'b0, 32'h0, 3'b000, 1'b0, 32'h0, 6'h01, 3'd0));
    vecs.push_back(mk(2'd0, 1'b0, 32'h0, 3'b000, 1'b0, 32'h0, 6'h00, 3'd0));
    vecs.push_back(mk(2'd1, 1'b1, 32'h6, 3'b110, 1'b0, 32'h0, 6'h00, 3'd0));
    vecs.push_back(mk(2'd0, 1'b0, 32'h0, 3'b110, 1'b1, 32'h2, 6'h02, 3'd1));
    vecs.push_back(mk(2'd0, 1'b0, 32'h0, 3'b110, 1'b0, 32'h0, 6'h02, 3'd1));
    vecs.push_back(mk(2'd0, 1'b0, 32'h0, 3'b110, 1'b1, 32'h6, 6'h06, 3'd1));
    vecs.push_back(mk(2'd1, 1'b1, 32'h4, 3'b110, 1'b1, 32'h6, 6'h04, 3'd2));
    vecs.push_back(mk(2'd0, 1'b0, 32'h0, 3'b110, 1'b1, 32'h6, 6'h04, 3'd2));
    vecs.push_back(mk(2'd3, 1'b0, 32'h0, 3'b110, 1'b1, 32'h1000_0002, 6'h04, 3'd2));
    vecs.push_back(mk(2'd0, 1'b1, 32'hFFFF_FFFF, 3'b110, 1'b1, 32'h6, 6'h04, 3'd2));
    vecs.push_back(mk(2'd1, 1'b1, 32'h0, 3'b000, 1'b1, 32'h4, 6'h00, 3'd0));
    vecs.push_back(mk(2'd0, 1'b0, 32'h0, 3'b000, 1'b0, 32'h0, 6'h00, 3'd0));
    vecs.push_back(mk(2'd0, 1'b0, 32'h0, 3'b000, 1'b0, 32'h0, 6'h00, 3'd0));
    vecs.push_back(mk(2'd0, 1'b0, 32'h0, 3'b000, 1'b1, 32'h0, 6'h00, 3'd0));

    foreach (vecs[i]) begin
      drive(vecs[i].sel, vecs[i].we, vecs[i].din, vecs[i].src);
      #1;
      if (vecs[i].chk_dout) chk($sformatf("vec%0d.dout", i), Dout, vecs[i].exp_dout);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].exp_hw, vecs[i].exp_id);
    end

    // Edge src1 with ACK
    drive(2'd1, 1'b1, 32'h2, 3'b000); step();
    drive(2'd2, 1'b1, 32'h2, 3'b000); step();
    drive(2'd0, 1'b0, 32'h0, 3'b010); step();
    chk_out("edge.k", 6'h00, 3'd0);
    drive(2'd0, 1'b0, 32'h0, 3'b000); step();
    chk_out("edge.k1", 6'h02, 3'd1);
    #1; chk("edge.pend", Dout, 32'h2);
    step();
    chk_out("edge.k2", 6'h02, 3'd1);
    drive(2'd3, 1'b1, 32'h2, 3'b000); step();
    chk_out("ack.k", 6'h02, 3'd1);
    drive(2'd0, 1'b0, 32'h0, 3'b000); step();
    chk_out("ack.k1", 6'h00, 3'd0);

    // New edge in the ACK cycle keeps pending set
    drive(2'd0, 1'b0, 32'h0, 3'b010); step();
    drive(2'd0, 1'b0, 32'h0, 3'b000); step();
    drive(2'd3, 1'b1, 32'h2, 3'b010); step();
    drive(2'd0, 1'b0, 32'h0, 3'b000); step(); step();
    chk_out("ackset", 6'h02, 3'd1);
    #1; chk("ackset.pend", Dout, 32'h2);
    drive(2'd3, 1'b1, 32'h2, 3'b000); step();
    drive(2'd0, 1'b0, 32'h0, 3'b000); step();

    // Held-high source does not re-fire after ACK
    drive(2'd0, 1'b0, 32'h0, 3'b010); step();
    drive(2'd3, 1'b1, 32'h2, 3'b010); step();
    drive(2'd0, 1'b0, 32'h0, 3'b010); step(); step(); step();
    chk_out("held", 6'h00, 3'd0);
    chk("held.pend", Dout, 32'h0);
    drive(2'd0, 1'b0, 32'h0, 3'b000); step();

    // Synchronised edge source src2, async-timed pulse
    drive(2'd1, 1'b1, 32'h4, 3'b000); step();
    drive(2'd2, 1'b1, 32'h4, 3'b000); step();
    drive(2'd0, 1'b0, 32'h0, 3'b000); step();
    #2 src = 3'b100;
    step(); chk_out("sync.k", 6'h00, 3'd0);
    step(); chk_out("sync.k1", 6'h00, 3'd0);
    #3 src = 3'b000;
    step(); chk_out("sync.k2", 6'h00, 3'd0);
    step(); chk_out("sync.k3", 6'h04, 3'd2);
    step(); chk_out("sync.k4", 6'h04, 3'd2);

    // Mode switch with src0 held high
    drive(2'd2, 1'b1, 32'h0, 3'b001); step();
    drive(2'd1, 1'b1, 32'h1, 3'b001); step();
    drive(2'd0, 1'b0, 32'h0, 3'b001); step(); step();
    chk_out("lvl.hold", 6'h01, 3'd0);
    chk("lvl.pend", Dout, 32'h1);
    drive(2'd2, 1'b1, 32'h1, 3'b001); step();
    drive(2'd0, 1'b0, 32'h0, 3'b001);
    #1; chk("mode.pend", Dout, 32'h0);
    step(); chk_out("mode.k1", 6'h00, 3'd0);
    step(); step(); chk_out("mode.held", 6'h00, 3'd0);
    drive(2'd0, 1'b0, 32'h0, 3'b000); step();
    drive(2'd0, 1'b0, 32'h0, 3'b001); step();
    chk_out("mode.rise", 6'h00, 3'd0);
    step(); chk_out("mode.fire", 6'h01, 3'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
